// File: rtl/xc_aessub.sv
// xc_aessub: AES SubBytes / InvSubBytes unit for the XCrypto execute stage.
// The S-box is computed (GF(2^8) inverse plus affine map), not tabled.
// FAST=1 instantiates four S-boxes and answers in the same cycle.
// FAST=0 shares one S-box across a four-state FSM, one byte per cycle.
module xc_aessub #(
  parameter logic FAST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
    return fwd ? affine(gf_inv(x)) : gf_inv(inv_affine(x));
  endfunction

  // Operand byte lanes: two from the low half of rs1, two from the high half of rs2.
  logic [7:0] b [4];
  assign b[0] = rs1[7:0];
  assign b[1] = rs1[15:8];
  assign b[2] = rs2[23:16];
  assign b[3] = rs2[31:24];

  // Remaining operand bits are architecturally ignored; clock/reset/flush are idle when FAST.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, rs1[31:16], rs2[15:0], clock, reset, flush};

  generate
    if (FAST) begin : g_fast
      logic [7:0] sb [4];
      genvar gi;
      for (gi = 0; gi < 4; gi++) begin : g_lane
        assign sb[gi] = sbox(b[gi], enc);
      end

      // Purely combinational: answer whenever inputs are valid, zero otherwise.
      always_comb begin
        ready  = valid;
        result = valid ? {sb[3], sb[2], sb[1], sb[0]} : 32'h0;
      end
    end else begin : g_slow
      state_t     state_reg;
      state_t     state_next;
      logic [7:0] r0_reg;
      logic [7:0] r1_reg;
      logic [7:0] r2_reg;
      logic [7:0] sbox_in;
      logic [7:0] sbox_out;

      // Shared S-box input follows the FSM: byte n is processed in state Sn.
      always_comb begin
        sbox_in = b[0];
        case (state_reg)
          S0:      sbox_in = b[0];
          S1:      sbox_in = b[1];
          S2:      sbox_in = b[2];
          default: sbox_in = b[3];
        endcase
        sbox_out = sbox(sbox_in, enc);
      end

      // Advance one state per valid cycle until S3; S3 is sticky until flush or reset.
      always_comb begin
        state_next = state_reg;
        if (flush) begin
          state_next = S0;
        end else if (valid && !ready) begin
          case (state_reg)
            S0:      state_next = S1;
            S1:      state_next = S2;
            S2:      state_next = S3;
            default: state_next = S3;
          endcase
        end
      end

      // State register and captured bytes; a flush cycle leaves the byte registers alone.
      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg <= S0;
          r0_reg    <= 8'h00;
          r1_reg    <= 8'h00;
          r2_reg    <= 8'h00;
        end else begin
          state_reg <= state_next;
          if (valid && !flush) begin
            if (state_reg == S0) r0_reg <= sbox_out;
            if (state_reg == S1) r1_reg <= sbox_out;
            if (state_reg == S2) r2_reg <= sbox_out;
          end
        end
      end

      // Top byte comes straight from the S-box in the final state; nothing leaks before ready.
      always_comb begin
        ready  = valid && (state_reg == S3);
        result = ready ? {sbox_out, r2_reg, r1_reg, r0_reg} : 32'h0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_xc_aessub.sv
// Directed bench for xc_aessub: one FAST=1 and one FAST=0 instance on shared operands.
module tb_xc_aessub;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        f_valid;
  logic        s_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        f_ready;
  logic        s_ready;
  logic [31:0] f_result;
  logic [31:0] s_result;

  int checks;
  int fails;

  xc_aessub #(.FAST(1'b1)) dut_fast (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .valid  (f_valid),
    .rs1    (rs1),
    .rs2    (rs2),
    .enc    (enc),
    .ready  (f_ready),
    .result (f_result)
  );

  xc_aessub #(.FAST(1'b0)) dut_slow (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .valid  (s_valid),
    .rs1    (rs1),
    .rs2    (rs2),
    .enc    (enc),
    .ready  (s_ready),
    .result (s_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  // Run one op on the shared-S-box unit, bounded wait for ready.
  task automatic run_slow(input logic e, input logic [31:0] a, input logic [31:0] c,
                          output logic [31:0] res);
    int n;
    pulse_flush();
    enc = e; rs1 = a; rs2 = c; s_valid = 1'b1;
    #1;
    n = 1;
    while (!s_ready && n < 8) begin
      cyc();
      n++;
    end
    chk("slow_latency", n, 4);
    res = s_result;
    cyc();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] fw;
    logic [31:0] orig;
    logic [31:0] res;
    logic [7:0]  v0, v1, v2, v3;

    checks = 0; fails = 0;
    reset = 1'b1; flush = 1'b0; f_valid = 1'b0; s_valid = 1'b0;
    rs1 = 32'h0; rs2 = 32'h0; enc = 1'b1;
    cyc(); cyc();
    chk("rst_s_ready", {31'b0, s_ready}, 32'h0);
    chk("rst_s_result", s_result, 32'h0);
    chk("rst_f_result", f_result, 32'h0);
    reset = 1'b0;

    // 1: forward, fast unit same cycle
    enc = 1'b1; rs1 = 32'h0000_5300; rs2 = 32'hFF01_0000; f_valid = 1'b1;
    #1;
    chk("t1_f_ready", {31'b0, f_ready}, 32'h1);
    chk("t1_f_result", f_result, 32'h167C_ED63);
    f_valid = 1'b0;
    #1;
    chk("t1_f_idle", f_result, 32'h0);

    // 1: forward, shared unit ready on 4th valid cycle
    s_valid = 1'b1;
    #1;
    chk("t1_c1_ready", {31'b0, s_ready}, 32'h0);
    chk("t1_c1_result", s_result, 32'h0);
    cyc();
    chk("t1_c2_ready", {31'b0, s_ready}, 32'h0);
    cyc();
    chk("t1_c3_ready", {31'b0, s_ready}, 32'h0);
    chk("t1_c3_result", s_result, 32'h0);
    cyc();
    chk("t1_c4_ready", {31'b0, s_ready}, 32'h1);
    chk("t1_c4_result", s_result, 32'h167C_ED63);
    cyc();
    chk("t1_hold_ready", {31'b0, s_ready}, 32'h1);
    s_valid = 1'b0;
    #1;
    chk("t1_nv_result", s_result, 32'h0);
    pulse_flush();

    // 2: inverse on both units
    enc = 1'b0; rs1 = 32'h0000_ED63; rs2 = 32'h167C_0000; f_valid = 1'b1; s_valid = 1'b1;
    #1;
    chk("t2_f_result", f_result, 32'hFF01_5300);
    f_valid = 1'b0;
    chk("t2_c1_ready", {31'b0, s_ready}, 32'h0);
    cyc(); cyc();
    chk("t2_c3_ready", {31'b0, s_ready}, 32'h0);
    cyc();
    chk("t2_c4_result", s_result, 32'hFF01_5300);
    s_valid = 1'b0;
    pulse_flush();

    // 3: valid dropped for two cycles mid-op
    enc = 1'b1; rs1 = 32'h0000_5300; rs2 = 32'hFF01_0000; s_valid = 1'b1;
    cyc(); cyc();
    s_valid = 1'b0;
    cyc();
    chk("t3_gap_ready", {31'b0, s_ready}, 32'h0);
    chk("t3_gap_result", s_result, 32'h0);
    cyc();
    s_valid = 1'b1;
    #1;
    chk("t3_resume_rdy", {31'b0, s_ready}, 32'h0);
    cyc();
    chk("t3_ready", {31'b0, s_ready}, 32'h1);
    chk("t3_result", s_result, 32'h167C_ED63);
    s_valid = 1'b0;
    pulse_flush();

    // 4: flush in S2 with valid high, then a fresh op
    s_valid = 1'b1;
    cyc(); cyc();
    flush = 1'b1;
    #1;
    chk("t4_flush_rdy", {31'b0, s_ready}, 32'h0);
    cyc();
    flush = 1'b0;
    enc = 1'b1; rs1 = 32'h0000_0010; rs2 = 32'h0;
    #1;
    chk("t4_s0_ready", {31'b0, s_ready}, 32'h0);
    cyc(); cyc();
    chk("t4_c3_ready", {31'b0, s_ready}, 32'h0);
    cyc();
    chk("t4_ready", {31'b0, s_ready}, 32'h1);
    chk("t4_result", s_result, 32'h6363_63CA);

    // 5: reset while sitting in S3 with valid still high
    reset = 1'b1;
    cyc();
    chk("t5_ready", {31'b0, s_ready}, 32'h0);
    chk("t5_result", s_result, 32'h0);
    reset = 1'b0;
    cyc(); cyc();
    chk("t5_c3_ready", {31'b0, s_ready}, 32'h0);
    cyc();
    chk("t5_result2", s_result, 32'h6363_63CA);
    s_valid = 1'b0;

    // 6: round-trip sweep of every byte value in every lane on the fast unit
    for (int i = 0; i < 256; i++) begin
      v0 = 8'(i); v1 = 8'(i) ^ 8'h5A; v2 = 8'(i + 37); v3 = ~8'(i);
      orig = {v3, v2, v1, v0};
      enc = 1'b1; rs1 = {16'h0, v1, v0}; rs2 = {v3, v2, 16'h0}; f_valid = 1'b1;
      #1;
      fw = f_result;
      enc = 1'b0; rs1 = {16'h0, fw[15:0]}; rs2 = {fw[31:16], 16'h0};
      #1;
      chk("sweep_rt", f_result, orig);
      if (i % 32 == 0) begin
        f_valid = 1'b0;
        #1;
        chk("sweep_idle", f_result, 32'h0);
        chk("sweep_s_idle", s_result, 32'h0);
      end
    end
    f_valid = 1'b0;

    // 6: a few round trips through the shared-S-box unit
    for (int i = 0; i < 6; i++) begin
      v0 = 8'(i * 41); v1 = 8'(i * 7 + 200); v2 = 8'(i * 90 + 3); v3 = 8'(255 - i * 13);
      orig = {v3, v2, v1, v0};
      run_slow(1'b1, {16'h0, v1, v0}, {v3, v2, 16'h0}, fw);
      run_slow(1'b0, {16'h0, fw[15:0]}, {fw[31:16], 16'h0}, res);
      chk("slow_rt", res, orig);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
